// File: rtl/chip_7458_tester.sv
// ---------------------------------------------------------------------------
// chip_7458_tester
//
// Exhaustive functional tester for one 7458 dual AND-OR gate package.
// A start request walks all 1024 input combinations across the ten device
// inputs. Each vector is held for SETTLE_CYCLES cycles and then compared
// during one CHECK cycle against the ideal 7458 function.
//
// Ports
//   clk            : sole clock, rising edge
//   reset          : asynchronous, active-high reset
//   start          : request a full run (ignored while busy)
//   p1a..p1f       : section-1 device inputs (vec[0]..vec[5])
//   p2a..p2d       : section-2 device inputs (vec[6]..vec[9])
//   p1y, p2y       : device outputs returned to the tester
//   busy           : run in progress (SETTLE or CHECK)
//   done           : run complete, results valid (DONE)
//   pass           : done with zero mismatches
//   err_count      : mismatching vectors in the last run (0..1024)
//   first_fail_vec : index of the first mismatching vector, 0 if none
// ---------------------------------------------------------------------------
module chip_7458_tester #(
    parameter int unsigned SETTLE_CYCLES = 1   // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        p1a,
    output logic        p1b,
    output logic        p1c,
    output logic        p1d,
    output logic        p1e,
    output logic        p1f,
    output logic        p2a,
    output logic        p2b,
    output logic        p2c,
    output logic        p2d,
    input  logic        p1y,
    input  logic        p2y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_count,
    output logic [9:0]  first_fail_vec
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [9:0]  LAST_VEC    = 10'd1023;
    localparam logic [10:0] ERR_MAX     = 11'd1024;

    state_t      state_q, state_d;
    logic [9:0]  vec_q, vec_d;
    logic [3:0]  scnt_q, scnt_d;
    logic [10:0] err_q, err_d;
    logic [9:0]  ffv_q, ffv_d;
    logic        fail_seen_q, fail_seen_d;

    logic        exp1, exp2, mismatch;
    logic [9:0]  drive;

    // Ideal device response, computed from the vector being applied.
    assign exp1     = (vec_q[0] & vec_q[1] & vec_q[2]) | (vec_q[3] & vec_q[4] & vec_q[5]);
    assign exp2     = (vec_q[6] & vec_q[7]) | (vec_q[8] & vec_q[9]);
    assign mismatch = (p1y != exp1) | (p2y != exp2);

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        scnt_d      = scnt_q;
        err_d       = err_q;
        ffv_d       = ffv_q;
        fail_seen_d = fail_seen_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    vec_d       = '0;
                    scnt_d      = '0;
                    err_d       = '0;
                    ffv_d       = '0;
                    fail_seen_d = 1'b0;
                    state_d     = SETTLE;
                end
            end

            SETTLE: begin
                scnt_d = 4'(scnt_q + 4'd1);
                if (scnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (mismatch) begin
                    // Saturate defensively; 1024 is only reachable if every vector fails.
                    if (err_q != ERR_MAX) begin
                        err_d = 11'(err_q + 11'd1);
                    end
                    if (!fail_seen_q) begin
                        ffv_d       = vec_q;
                        fail_seen_d = 1'b1;
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    vec_d   = 10'(vec_q + 10'd1);
                    scnt_d  = '0;
                    state_d = SETTLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            scnt_q      <= '0;
            err_q       <= '0;
            ffv_q       <= '0;
            fail_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            scnt_q      <= scnt_d;
            err_q       <= err_d;
            ffv_q       <= ffv_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    // Status and pin drive decode directly from state flops (no extra delay).
    assign busy  = (state_q == SETTLE) || (state_q == CHECK);
    assign done  = (state_q == DONE);
    assign pass  = done && (err_q == '0);
    assign drive = busy ? vec_q : 10'd0;

    assign err_count      = err_q;
    assign first_fail_vec = ffv_q;

    assign p1a = drive[0];
    assign p1b = drive[1];
    assign p1c = drive[2];
    assign p1d = drive[3];
    assign p1e = drive[4];
    assign p1f = drive[5];
    assign p2a = drive[6];
    assign p2b = drive[7];
    assign p2c = drive[8];
    assign p2d = drive[9];

endmodule

// File: tb/tb_chip_7458_tester.sv
// ---------------------------------------------------------------------------
// tb_chip_7458_tester
//
// Two testers: dut0 with SETTLE_CYCLES=1 driving a 7458 model whose outputs
// can be stuck or inverted via fault_mode, and dut3 with SETTLE_CYCLES=3
// driving an ideal 7458 model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_chip_7458_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start0, start3;
    int   fault_mode;  // 0 ideal, 1 p1y stuck 0, 2 p2y stuck 1, 3 both inverted

    logic [9:0]  pins0, pins3;
    logic        p1y0, p2y0, p1y3, p2y3;
    logic        busy0, done0, pass0, busy3, done3, pass3;
    logic [10:0] err0, err3;
    logic [9:0]  ffv0, ffv3;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference 7458 device models
    logic g1_0, g2_0, g1_3, g2_3;
    assign g1_0 = (pins0[0] & pins0[1] & pins0[2]) | (pins0[3] & pins0[4] & pins0[5]);
    assign g2_0 = (pins0[6] & pins0[7]) | (pins0[8] & pins0[9]);
    assign g1_3 = (pins3[0] & pins3[1] & pins3[2]) | (pins3[3] & pins3[4] & pins3[5]);
    assign g2_3 = (pins3[6] & pins3[7]) | (pins3[8] & pins3[9]);

    assign p1y0 = (fault_mode == 1) ? 1'b0 : (fault_mode == 3) ? ~g1_0 : g1_0;
    assign p2y0 = (fault_mode == 2) ? 1'b1 : (fault_mode == 3) ? ~g2_0 : g2_0;
    assign p1y3 = g1_3;
    assign p2y3 = g2_3;

    chip_7458_tester #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .reset(rst), .start(start0),
        .p1a(pins0[0]), .p1b(pins0[1]), .p1c(pins0[2]), .p1d(pins0[3]),
        .p1e(pins0[4]), .p1f(pins0[5]), .p2a(pins0[6]), .p2b(pins0[7]),
        .p2c(pins0[8]), .p2d(pins0[9]),
        .p1y(p1y0), .p2y(p2y0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_fail_vec(ffv0)
    );

    chip_7458_tester #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(rst), .start(start3),
        .p1a(pins3[0]), .p1b(pins3[1]), .p1c(pins3[2]), .p1d(pins3[3]),
        .p1e(pins3[4]), .p1f(pins3[5]), .p2a(pins3[6]), .p2b(pins3[7]),
        .p2c(pins3[8]), .p2d(pins3[9]),
        .p1y(p1y3), .p2y(p2y3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_fail_vec(ffv3)
    );

    // Pulse start on the selected tester, then follow the run edge by edge.
    // Edge 0 is the start edge; after edge n the applied vector must be
    // n/(settle+1) and busy must be high until done rises.
    task automatic run(input int sel, input int repulse_at, output int cycles);
        int settle, hold_bad, busy_bad, limit;
        logic [9:0] exp_vec, pins_now;
        settle   = (sel == 3) ? 3 : 1;
        limit    = 1024 * (settle + 1) + 200;
        hold_bad = 0;
        busy_bad = 0;
        cycles   = -1;
        @(negedge clk);
        if (sel == 3) start3 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start3 = 1'b0;
        for (int n = 0; n < limit; n++) begin
            if (n == repulse_at)     start0 = 1'b1;
            if (n == repulse_at + 1) start0 = 1'b0;
            if ((sel == 3) ? done3 : done0) begin
                cycles = n;
                break;
            end
            if (!((sel == 3) ? busy3 : busy0)) busy_bad++;
            exp_vec  = 10'(n / (settle + 1));
            pins_now = (sel == 3) ? pins3 : pins0;
            if (pins_now !== exp_vec) begin
                if (hold_bad == 0)
                    $display("FAIL pin_hold edge=%0d got=%0d expected=%0d", n, pins_now, exp_vec);
                hold_bad++;
            end
            @(posedge clk); #1;
        end
        start0 = 1'b0;
        n_checks++;
        if (cycles < 0) begin
            n_fail++;
            $display("FAIL run_timeout sel=%0d got no done within %0d edges", sel, limit);
        end
        n_checks++;
        if (hold_bad != 0) begin
            n_fail++;
            $display("FAIL pin_hold_total sel=%0d got %0d bad edges expected 0", sel, hold_bad);
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL busy_during_run sel=%0d got %0d low edges expected 0", sel, busy_bad);
        end
    endtask

    task automatic check_results0(input string tag, input int cyc, input int exp_cyc,
                                  input logic exp_pass, input int exp_err, input int exp_ffv);
        n_checks++;
        if (cyc !== exp_cyc) begin
            n_fail++; $display("FAIL %s_cycles got=%0d expected=%0d", tag, cyc, exp_cyc);
        end
        n_checks++;
        if (done0 !== 1'b1 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL %s_done got done=%b busy=%b expected 1/0", tag, done0, busy0);
        end
        n_checks++;
        if (pass0 !== exp_pass) begin
            n_fail++; $display("FAIL %s_pass got=%b expected=%b", tag, pass0, exp_pass);
        end
        n_checks++;
        if (err0 !== 11'(exp_err)) begin
            n_fail++; $display("FAIL %s_err_count got=%0d expected=%0d", tag, err0, exp_err);
        end
        n_checks++;
        if (ffv0 !== 10'(exp_ffv)) begin
            n_fail++; $display("FAIL %s_first_fail got=%0d expected=%0d", tag, ffv0, exp_ffv);
        end
        $display("run %s: cycles=%0d err_count=%0d first_fail_vec=%0d pass=%b",
                 tag, cyc, err0, ffv0, pass0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b1; start3 = 1'b0; fault_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy0, done0, pass0} !== 3'b000) begin
            n_fail++; $display("FAIL reset_status got=%b expected=000", {busy0, done0, pass0});
        end
        n_checks++;
        if (err0 !== 11'd0 || ffv0 !== 10'd0) begin
            n_fail++; $display("FAIL reset_counts got err=%0d ffv=%0d expected 0/0", err0, ffv0);
        end
        n_checks++;
        if (pins0 !== 10'd0 || pins3 !== 10'd0) begin
            n_fail++; $display("FAIL reset_pins got=%h/%h expected 0/0", pins0, pins3);
        end
        @(negedge clk);
        start0 = 1'b0;
        rst    = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || pins0 !== 10'd0) begin
            n_fail++; $display("FAIL idle_after_reset got busy=%b done=%b pins=%h expected 0/0/0",
                               busy0, done0, pins0);
        end
        $display("reset: busy=%b done=%b err=%0d pins=%h", busy0, done0, err0, pins0);
    endtask

    task automatic test_golden();
        int c;
        fault_mode = 0;
        run(0, -1, c);
        check_results0("golden", c, 2048, 1'b1, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (done0 !== 1'b1 || pass0 !== 1'b1 || pins0 !== 10'd0) begin
            n_fail++; $display("FAIL done_hold got done=%b pass=%b pins=%h expected 1/1/0",
                               done0, pass0, pins0);
        end
    endtask

    task automatic test_p1y_stuck();
        int c;
        fault_mode = 1;
        run(0, -1, c);
        check_results0("p1y_stuck0", c, 2048, 1'b0, 240, 7);
    endtask

    task automatic test_p2y_stuck();
        int c;
        fault_mode = 2;
        run(0, -1, c);
        check_results0("p2y_stuck1", c, 2048, 1'b0, 576, 0);
    endtask

    task automatic test_inverted();
        int c;
        fault_mode = 3;
        run(0, -1, c);
        check_results0("inverted", c, 2048, 1'b0, 1024, 0);
    endtask

    task automatic test_reset_mid_run();
        int c;
        fault_mode = 1;  // faulty device so partial results would be nonzero
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (201) @(posedge clk);
        #1;
        n_checks++;
        if (pins0 !== 10'd100) begin
            n_fail++; $display("FAIL mid_run_vec got=%0d expected=100", pins0);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (pins0 !== 10'd0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got pins=%h busy=%b done=%b expected 0/0/0",
                               pins0, busy0, done0);
        end
        n_checks++;
        if (err0 !== 11'd0 || ffv0 !== 10'd0) begin
            n_fail++; $display("FAIL reset_clears got err=%0d ffv=%0d expected 0/0", err0, ffv0);
        end
        $display("mid-run reset: pins=%h busy=%b err=%0d", pins0, busy0, err0);
        @(negedge clk);
        rst = 1'b0;
        fault_mode = 0;
        repeat (3) @(posedge clk);
        run(0, -1, c);
        check_results0("after_reset", c, 2048, 1'b1, 0, 0);
    endtask

    task automatic test_start_ignored();
        int c;
        fault_mode = 1;
        run(0, 1000, c);
        check_results0("start_repulse", c, 2048, 1'b0, 240, 7);
    endtask

    task automatic test_settle3();
        int c;
        run(3, -1, c);
        n_checks++;
        if (c !== 4096) begin
            n_fail++; $display("FAIL settle3_cycles got=%0d expected=4096", c);
        end
        n_checks++;
        if (pass3 !== 1'b1 || err3 !== 11'd0 || ffv3 !== 10'd0) begin
            n_fail++; $display("FAIL settle3_result got pass=%b err=%0d ffv=%0d expected 1/0/0",
                               pass3, err3, ffv3);
        end
        $display("run settle3: cycles=%0d err_count=%0d pass=%b", c, err3, pass3);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_p1y_stuck();
        test_p2y_stuck();
        test_inverted();
        test_reset_mid_run();
        test_start_ignored();
        test_settle3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chip_7458_tester.md
CHIP_7458_TESTER -- requirements
Module: chip_7458_tester

Interface
- REQ-001 Parameter SETTLE_CYCLES, default 1: cycles each vector is held before sampling; legal range 1..15.
- REQ-002 clk  input  1  sole clock; all state updates on rising edge.
- REQ-003 reset  input  1  asynchronous, active-high reset.
- REQ-004 start  input  1  request a full exhaustive run; sampled on clk.
- REQ-005 p1a, p1b, p1c, p1d, p1e, p1f  output  1 each  drive the 7458 section-1 inputs.
- REQ-006 p2a, p2b, p2c, p2d  output  1 each  drive the 7458 section-2 inputs.
- REQ-007 p1y, p2y  input  1 each  outputs returned from the device under test.
- REQ-008 busy  output  1  run in progress.
- REQ-009 done  output  1  run complete; results valid.
- REQ-010 pass  output  1  high when done=1 and err_count=0.
- REQ-011 err_count  output  11  number of mismatching vectors in the last run (0..1024).
- REQ-012 first_fail_vec  output  10  index of the first mismatching vector; 0 if none.

Function
- REQ-013 The FSM SHALL have states IDLE, SETTLE, CHECK and DONE, with vector register vec[9:0] and settle counter scnt[3:0].
- REQ-014 Vector mapping while busy: p1a..p1f = vec[0]..vec[5]; p2a..p2d = vec[6]..vec[9].
- REQ-015 In IDLE and DONE, all p1*/p2* outputs SHALL be 0.
- REQ-016 Expected values: exp1 = (p1a&p1b&p1c)|(p1d&p1e&p1f); exp2 = (p2a&p2b)|(p2c&p2d).
- REQ-017 IDLE or DONE with start=1 at an edge:
  - vec<=0, scnt<=0, err_count<=0, first_fail_vec<=0, fail_seen<=0, done<=0;
  - go to SETTLE; busy=1 from that edge.
- REQ-018 SETTLE: scnt increments each cycle; at the edge where scnt = SETTLE_CYCLES-1, go to CHECK.
- REQ-019 CHECK (one cycle), at its closing edge:
  - a mismatch is (p1y!=exp1)|(p2y!=exp2);
  - on mismatch, increment err_count; if fail_seen=0, also load first_fail_vec<=vec and set fail_seen.
- REQ-020 CHECK exit: if vec=1023, go to DONE; else vec<=vec+1, scnt<=0, go to SETTLE.
- REQ-021 Each vector therefore occupies SETTLE_CYCLES+1 cycles; DONE is entered 1024*(SETTLE_CYCLES+1) edges after the start edge (2048 at default).
- REQ-022 busy=1 exactly in SETTLE and CHECK.
- REQ-023 done=1 exactly in DONE; done holds until the next accepted start or reset.
- REQ-024 start while busy SHALL be ignored, with no effect on vec, counters or state.
- REQ-025 err_count SHALL NOT wrap; the maximum is 1024 (all vectors failing).
- REQ-026 err_count, first_fail_vec and pass SHALL hold their values in DONE until the next accepted start.

Reset
- REQ-027 While reset=1, asynchronously:
  - state=IDLE; vec=0; scnt=0; fail_seen=0;
  - busy=0, done=0, pass=0, err_count=0, first_fail_vec=0;
  - all p1*/p2* outputs = 0.
- REQ-028 Reset mid-run SHALL abandon the run with no partial results retained.
- REQ-029 After reset deasserts, the block SHALL idle until start.

Verification
- REQ-030 Golden 7458 model connected, SETTLE_CYCLES=1, 1-cycle start pulse -> busy for 2048 cycles; done=1, pass=1, err_count=0, first_fail_vec=0.
- REQ-031 p1y tied to 0 -> done, pass=0, err_count=240, first_fail_vec=7.
- REQ-032 p2y tied to 1 -> err_count=576, first_fail_vec=0.
- REQ-033 Both outputs inverted from the golden model -> err_count=1024, first_fail_vec=0, pass=0.
- REQ-034 Reset asserted while vec=100, then released, then start -> outputs 0 during reset; the new run begins at vec=0 and ends with err_count=0 on the golden model.
- REQ-035 Start re-pulsed at vec=500 -> ignored, DONE still reached at cycle 2048. Then SETTLE_CYCLES=3 -> DONE at cycle 4096, with each vector held 4 cycles on p1*/p2*.
